fibo_inv: RTL and testbench

- Inverse Fibonacci FSMD: the decoding counterpart of the Fibonacci generator block.
- Takes a 20-bit value `f` and returns index `i`, the largest n with fib(n) <= f, plus an `exact` flag that is set when fib(i) == f.
- Uses the same start/ready/done_tick handshake as the generator, so generator output can be looped back for round-trip checks.
- Sequence definition: fib(0)=0, fib(1)=1, fib(n)=fib(n-1)+fib(n-2).

---
 rtl/fibo_inv.sv | 105 ++++++++++
 tb/tb_fibo_inv.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fibo_inv.sv
// rtl/fibo_inv.sv - inverse Fibonacci FSMD: largest n with fib(n) <= f, plus exact-match flag
// Walks the sequence from fib(0) until fib(n+1) exceeds the latched value.
module fibo_inv #(
   parameter int W  = 20,
   parameter int IW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  f,
   output logic          ready,
   output logic          done_tick,
   output logic [IW-1:0] i,
   output logic          exact
);

   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

   state_t        state_q, state_d;
   logic [W:0]    t0_q, t0_d;
   logic [W:0]    t1_q, t1_d;
   logic [IW-1:0] n_q, n_d;
   logic [W-1:0]  fr_q, fr_d;
   logic [IW-1:0] i_q, i_d;
   logic          exact_q, exact_d;
   logic          ready_q, ready_d;
   logic          done_tick_q, done_tick_d;
   logic [W:0]    fr_ext;

   assign fr_ext = {1'b0, fr_q};

   always_comb begin
      state_d     = state_q;
      t0_d        = t0_q;
      t1_d        = t1_q;
      n_d         = n_q;
      fr_d        = fr_q;
      i_d         = i_q;
      exact_d     = exact_q;
      ready_d     = ready_q;
      done_tick_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               fr_d    = f;
               t0_d    = '0;
               t1_d    = {{W{1'b0}}, 1'b1};
               n_d     = '0;
               ready_d = 1'b0;
               state_d = OP;
            end
         end
         OP: begin
            if (t1_q > fr_ext) begin
               i_d         = n_q;
               exact_d     = (t0_q == fr_ext);
               done_tick_d = 1'b1;
               state_d     = DONE;
            end else begin
               t0_d = t1_q;
               t1_d = t0_q + t1_q;
               n_d  = n_q + 1'b1;
            end
         end
         DONE: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         t0_q        <= '0;
         t1_q        <= '0;
         n_q         <= '0;
         fr_q        <= '0;
         i_q         <= '0;
         exact_q     <= 1'b0;
         ready_q     <= 1'b1;
         done_tick_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         t0_q        <= t0_d;
         t1_q        <= t1_d;
         n_q         <= n_d;
         fr_q        <= fr_d;
         i_q         <= i_d;
         exact_q     <= exact_d;
         ready_q     <= ready_d;
         done_tick_q <= done_tick_d;
      end
   end

   assign ready     = ready_q;
   assign done_tick = done_tick_q;
   assign i         = i_q;
   assign exact     = exact_q;

endmodule

// File: tb/tb_fibo_inv.sv
// tb/tb_fibo_inv.sv - directed vector bench for fibo_inv
// Requests are issued one edge at a time; outputs are sampled 1 ns after the rising edge.
module tb_fibo_inv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [19:0] f = '0;
   logic        ready;
   logic        done_tick;
   logic [4:0]  i_o;
   logic        exact;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [19:0] fv;
      int          ei;
      int          ee;
   } vec_t;

   vec_t vecs [12];

   fibo_inv #(.W(20), .IW(5)) dut (
      .clk(clk), .rst(rst), .start(start), .f(f),
      .ready(ready), .done_tick(done_tick), .i(i_o), .exact(exact)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Counts rising edges until done_tick is seen; 0 means the bound expired.
   task automatic wait_done(output int cyc);
      int c;
      bit got;
      c = 0;
      got = 0;
      while (!got && c < 64) begin
         @(posedge clk); #1;
         c++;
         if (done_tick) got = 1;
      end
      cyc = got ? c : 0;
   endtask

   task automatic accept(input logic [19:0] fv);
      start = 1'b1;
      f = fv;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_req(input logic [19:0] fv, input int ei, input int ee, input string nm);
      int cyc;
      accept(fv);
      wait_done(cyc);
      check({nm, " latency"}, cyc, ei + 1);
      check({nm, " i"}, int'(i_o), ei);
      check({nm, " exact"}, int'(exact), ee);
      check({nm, " ready in done"}, int'(ready), 0);
      @(posedge clk); #1;
      check({nm, " done_tick width"}, int'(done_tick), 0);
      check({nm, " ready after"}, int'(ready), 1);
   endtask

   initial begin
      int cyc;
      vecs[0]  = '{20'd0,      0,  1};
      vecs[1]  = '{20'd1,      2,  1};
      vecs[2]  = '{20'd2,      3,  1};
      vecs[3]  = '{20'd4,      4,  0};
      vecs[4]  = '{20'd5,      5,  1};
      vecs[5]  = '{20'd100,    11, 0};
      vecs[6]  = '{20'd144,    12, 1};
      vecs[7]  = '{20'd1000,   16, 0};
      vecs[8]  = '{20'd832039, 29, 0};
      vecs[9]  = '{20'd832040, 30, 1};
      vecs[10] = '{20'hFFFFF,  30, 0};
      vecs[11] = '{20'd13,     7,  1};

      #12;
      check("reset ready", int'(ready), 1);
      check("reset done_tick", int'(done_tick), 0);
      check("reset i", int'(i_o), 0);
      check("reset exact", int'(exact), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 12; k++)
         do_req(vecs[k].fv, vecs[k].ei, vecs[k].ee, $sformatf("vec%0d", k));

      // f and start poked while busy must not disturb the latched request
      accept(20'd100);
      f = 20'd5;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      f = 20'd0;
      wait_done(cyc);
      check("busy latency", (cyc == 0) ? 0 : cyc + 2, 12);
      check("busy i", int'(i_o), 11);
      check("busy exact", int'(exact), 0);
      @(posedge clk); #1;

      // start held high: re-accepted on the first IDLE edge after DONE
      start = 1'b1;
      f = 20'd5;
      @(posedge clk); #1;
      wait_done(cyc);
      check("held first latency", cyc, 6);
      check("held first i", int'(i_o), 5);
      @(posedge clk); #1;
      check("held idle ready", int'(ready), 1);
      @(posedge clk); #1;
      check("held reaccept ready", int'(ready), 0);
      start = 1'b0;
      f = 20'd13;
      wait_done(cyc);
      check("held second latency", cyc, 6);
      check("held second i", int'(i_o), 5);
      check("held second exact", int'(exact), 1);
      @(posedge clk); #1;

      // asynchronous reset in the middle of OP
      accept(20'd1000);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midop rst ready", int'(ready), 1);
      check("midop rst i", int'(i_o), 0);
      check("midop rst exact", int'(exact), 0);
      check("midop rst done_tick", int'(done_tick), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      do_req(20'd13, 7, 1, "post reset");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
